// File: rtl/canny_pkg.sv
// Shared types for the Canny hysteresis stage: pixel classes, FSM states,
// image size defaults and the double-threshold classifier.
package canny_pkg;

    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } pix_class_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } hyst_state_t;

    // Unsigned double-threshold classification. With lo > hi the weak band
    // is empty: anything >= lo is already >= hi and therefore strong.
    function automatic pix_class_t classify(input logic [31:0] mag,
                                            input logic [31:0] hi,
                                            input logic [31:0] lo);
        if (mag >= hi)
            return CLS_STRONG;
        else if (mag >= lo)
            return CLS_WEAK;
        else
            return CLS_NONE;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// DEPTH-deep delay line for pixel classes. The output is the entry written
// DEPTH shifts ago; it is read before being overwritten on a shift.
module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;

    assign o_q = r_mem[r_ptr];

    // Circular pointer advances once per shift.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (i_shift)
            r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
    end

    // Storage is never cleared; consumers mask out stale rows.
    always_ff @(posedge clk) begin
        if (i_shift)
            r_mem[r_ptr] <= i_d;
    end

endmodule

// File: rtl/hysteresis_filter.sv
// Streaming double-threshold hysteresis for the Canny pipeline.
// Optional feature: define HYST_EDGE_COUNT_EN to add the edge_count output.
module hysteresis_filter
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int MAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] mag_in,
    input  logic             mag_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] high_thresh,
    input  logic [MAG_W-1:0] low_thresh,
    output logic             hysteresis_result,
    output logic             write_enable,
    output logic             frame_done
`ifdef HYST_EDGE_COUNT_EN
    ,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] edge_count
`endif
);

    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int FW = $clog2(IMG_WIDTH + 1);

    hyst_state_t      r_state, w_state_nxt;
    logic [XW-1:0]    r_x, r_cx;
    logic [YW-1:0]    r_y, r_cy;
    logic [FW-1:0]    r_fcnt;
    logic [MAG_W-1:0] r_hi, r_lo;
    logic             r_we, r_res, r_fd;

    // Two older window columns per row: [row][0] = centre-1, [row][1] = centre.
    logic [1:0] r_win [3][2];

    logic             w_acc, w_flush, w_step, w_emit, w_first;
    logic [MAG_W-1:0] w_hi, w_lo;
    logic [1:0]       w_cls, w_lb0, w_lb1;
    logic [1:0]       w_col_new [3];
    logic [1:0]       w_win [3][3];
    logic [2:0]       w_col_ok, w_row_ok;
    logic             w_strong_nb, w_edge;

    assign w_acc   = mag_valid & in_ready;
    assign w_flush = (r_state == FLUSH);
    assign w_step  = w_acc | w_flush;
    assign w_emit  = ((r_state == RUN) & w_acc) | w_flush;
    assign w_first = (r_state == FILL) && (r_x == '0) && (r_y == '0);

    // Thresholds apply from the first pixel of the frame onward.
    assign w_hi  = w_first ? high_thresh : r_hi;
    assign w_lo  = w_first ? low_thresh  : r_lo;
    assign w_cls = w_flush ? CLS_NONE : classify(32'(mag_in), 32'(w_hi), 32'(w_lo));

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(2)) u_lb0 (
        .clk(clk), .rst(rst), .i_shift(w_step), .i_d(w_cls), .o_q(w_lb0)
    );
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(2)) u_lb1 (
        .clk(clk), .rst(rst), .i_shift(w_step), .i_d(w_lb0), .o_q(w_lb1)
    );

    // Newest column: two rows up, one row up, and the entering pixel.
    assign w_col_new[0] = w_lb1;
    assign w_col_new[1] = w_lb0;
    assign w_col_new[2] = w_cls;

    // Border masks relative to the centre pixel; no wrap across rows.
    assign w_col_ok = {r_cx != XW'(IMG_WIDTH - 1), 1'b1, r_cx != '0};
    assign w_row_ok = {r_cy != YW'(IMG_HEIGHT - 1), 1'b1, r_cy != '0};

    // Assemble the 3x3 window and look for any in-image strong neighbour.
    always_comb begin
        w_strong_nb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            w_win[r][0] = r_win[r][0];
            w_win[r][1] = r_win[r][1];
            w_win[r][2] = w_col_new[r];
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!(r == 1 && c == 1) && w_row_ok[r] && w_col_ok[c] &&
                    w_win[r][c] == CLS_STRONG)
                    w_strong_nb = 1'b1;
    end

    assign w_edge = (w_win[1][1] == CLS_STRONG) ||
                    ((w_win[1][1] == CLS_WEAK) && w_strong_nb);

    // Window shift register advances with every accept or flush step.
    always_ff @(posedge clk) begin
        if (w_step) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col_new[r];
            end
        end
    end

    // Latch thresholds on the first accepted pixel of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_first && w_acc) begin
            r_hi <= high_thresh;
            r_lo <= low_thresh;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= FILL;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                // Accepting pixel index W completes the W+1 fill pixels.
                if (w_acc && r_x == '0 && r_y == YW'(1))
                    w_state_nxt = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (w_acc && r_x == XW'(IMG_WIDTH - 1) && r_y == YW'(IMG_HEIGHT - 1))
                    w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (r_fcnt == FW'(IMG_WIDTH))
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Input position, centre position and flush step counters.
    always_ff @(posedge clk) begin
        if (rst || r_state == DONE) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_acc) begin
                if (r_x == XW'(IMG_WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == YW'(IMG_HEIGHT - 1)) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            if (w_emit) begin
                if (r_cx == XW'(IMG_WIDTH - 1)) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == YW'(IMG_HEIGHT - 1)) ? '0 : r_cy + YW'(1);
                end else begin
                    r_cx <= r_cx + XW'(1);
                end
            end
            if (w_flush)
                r_fcnt <= r_fcnt + FW'(1);
        end
    end

    // Registered outputs; frame_done follows the last write by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_res <= 1'b0;
            r_fd  <= 1'b0;
        end else begin
            r_we  <= w_emit;
            r_res <= w_emit & w_edge;
            r_fd  <= (r_state == DONE);
        end
    end

    assign write_enable      = r_we;
    assign hysteresis_result = r_res;
    assign frame_done        = r_fd;

`ifdef HYST_EDGE_COUNT_EN
    localparam int ECW = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
    logic [ECW-1:0] r_ec;

    // Running edge count, restarted by the first output of each frame.
    always_ff @(posedge clk) begin
        if (rst)
            r_ec <= '0;
        else if (w_emit)
            r_ec <= (r_cx == '0 && r_cy == '0) ? ECW'(w_edge) : r_ec + ECW'(w_edge);
    end

    assign edge_count = r_ec;
`endif

endmodule

// File: tb/tb_hysteresis_filter.sv
// Directed, table-driven bench for hysteresis_filter on a 4x4 image.
module tb_hysteresis_filter;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mag_in, high_thresh, low_thresh;
    logic       mag_valid;
    logic       in_ready, hysteresis_result, write_enable, frame_done;
`ifdef HYST_EDGE_COUNT_EN
    logic [$clog2(N+1)-1:0] edge_count;
`endif

    always #5 clk = ~clk;

    hysteresis_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(8)) dut (
        .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid),
        .in_ready(in_ready), .high_thresh(high_thresh), .low_thresh(low_thresh),
        .hysteresis_result(hysteresis_result), .write_enable(write_enable),
        .frame_done(frame_done)
`ifdef HYST_EDGE_COUNT_EN
        , .edge_count(edge_count)
`endif
    );

    typedef struct {
        logic [7:0]   mag [N];
        logic [7:0]   hi;
        logic [7:0]   lo;
        logic         gap;
        logic         chg;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vt [8];

    int passed = 0;
    int total  = 0;

    int         cyc = 0;
    logic       rdy;
    int         n_out, n_done, done_cyc, first_out_cyc, last_out_cyc, low_cnt, idle_out;
    logic [N-1:0] res;
    int         acc_cyc [$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] hi, input logic [7:0] lo,
                                input logic gap, input logic chg, input logic [N-1:0] exp);
        vec_t v;
        for (int i = 0; i < N; i++) v.mag[i] = 8'd0;
        v.hi = hi; v.lo = lo; v.gap = gap; v.chg = chg; v.exp = exp;
        return v;
    endfunction

    // One clock: drive at negedge, sample outputs at the next negedge.
    task automatic tick(input logic v, input logic [7:0] m, output logic acc);
        logic prev_rdy;
        mag_valid = v;
        mag_in    = m;
        prev_rdy  = rdy;
        @(posedge clk);
        cyc++;
        acc = v && prev_rdy;
        @(negedge clk);
        rdy = in_ready;
        if (acc) acc_cyc.push_back(cyc);
        if (!in_ready) low_cnt++;
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (write_enable) begin
            if (n_out < N) res[n_out] = hysteresis_result;
            if (n_out == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_out++;
            if (!v && prev_rdy) idle_out++;
        end
    endtask

    task automatic clear_stats();
        n_out = 0; n_done = 0; done_cyc = -1; first_out_cyc = -1;
        last_out_cyc = -1; low_cnt = 0; idle_out = 0; res = '0;
        acc_cyc.delete();
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int   i, guard;
        logic acc, ph;
        clear_stats();
        high_thresh = v.hi;
        low_thresh  = v.lo;
        i = 0; guard = 0; ph = 1'b1;
        while (i < N && guard < 200) begin
            logic vv;
            vv = v.gap ? ph : 1'b1;
            ph = ~ph;
            tick(vv, vv ? v.mag[i] : 8'd0, acc);
            if (acc) begin
                i++;
                if (i == 1 && v.chg) begin high_thresh = 8'd0; low_thresh = 8'd0; end
            end
            guard++;
        end
        check($sformatf("v%0d accepts", id), i, N);
        guard = 0;
        while (n_done == 0 && guard < 100) begin
            tick(1'b0, 8'd0, acc);
            guard++;
        end
        check($sformatf("v%0d frame_done count", id), n_done, 1);
        check($sformatf("v%0d outputs", id), n_out, N);
        for (int k = 0; k < N; k++)
            check($sformatf("v%0d result[%0d]", id, k), int'(res[k]), int'(v.exp[k]));
        if (acc_cyc.size() == N) begin
            check($sformatf("v%0d first output latency", id), first_out_cyc, acc_cyc[W+1]);
            check($sformatf("v%0d last output cycle", id), last_out_cyc, acc_cyc[N-1] + W + 1);
        end else begin
            check($sformatf("v%0d accept log size", id), acc_cyc.size(), N);
        end
        check($sformatf("v%0d frame_done timing", id), done_cyc, last_out_cyc + 1);
        check($sformatf("v%0d in_ready low cycles", id), low_cnt, W + 2);
        check($sformatf("v%0d outputs on idle cycles", id), idle_out, 0);
        high_thresh = v.hi;
        low_thresh  = v.lo;
    endtask

    initial begin
        logic acc;
        // Vector table: magnitude pattern, thresholds, modes, expected edge bits.
        vt[0] = mk(8'd100, 8'd50, 1'b0, 1'b0, 16'h0000);          // all zero
        vt[1] = mk(8'd100, 8'd50, 1'b0, 1'b0, 16'h0420);          // strong + weak chain
        vt[1].mag[5] = 8'd200; vt[1].mag[10] = 8'd60; vt[1].mag[15] = 8'd60;
        vt[2] = mk(8'd100, 8'd50, 1'b0, 1'b0, 16'h0008);          // no row wrap
        vt[2].mag[3] = 8'd200; vt[2].mag[4] = 8'd60;
        vt[3] = mk(8'd100, 8'd50, 1'b1, 1'b0, 16'h0000);          // gaps, all zero
        vt[4] = vt[1]; vt[4].gap = 1'b1;                          // gaps, pattern
        vt[5] = mk(8'd100, 8'd50, 1'b0, 1'b0, 16'h0021);          // threshold boundaries
        vt[5].mag[0] = 8'd50; vt[5].mag[5] = 8'd100; vt[5].mag[12] = 8'd99; vt[5].mag[15] = 8'd49;
        vt[6] = mk(8'd100, 8'd150, 1'b0, 1'b0, 16'h0005);         // low > high: no weak
        vt[6].mag[0] = 8'd120; vt[6].mag[1] = 8'd99; vt[6].mag[2] = 8'd160;
        vt[7] = mk(8'd100, 8'd50, 1'b0, 1'b1, 16'h0000);          // thresholds latched
        vt[7].mag[5] = 8'd60;

        rst = 1'b1; mag_valid = 1'b0; mag_in = 8'd0;
        high_thresh = 8'd100; low_thresh = 8'd50;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy = in_ready;
        check("reset write_enable", int'(write_enable), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset result", int'(hysteresis_result), 0);

        for (int t = 0; t < 8; t++)
            run_frame(t, vt[t]);

        // Abort mid-frame with strong pixels buffered, then run a clean frame.
        clear_stats();
        for (int k = 0; k < 7; k++) tick(1'b1, 8'd200, acc);
        rst = 1'b1; mag_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy = in_ready;
        check("mid-reset write_enable", int'(write_enable), 0);
        check("mid-reset in_ready", int'(in_ready), 1);
        begin
            vec_t vr;
            vr = mk(8'd100, 8'd50, 1'b0, 1'b0, 16'h0001);
            vr.mag[0] = 8'd200;
            run_frame(8, vr);
        end
`ifdef HYST_EDGE_COUNT_EN
        check("edge_count after frame", int'(edge_count), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hysteresis_filter.md
Name: hysteresis_filter

Overview:
Streaming double-threshold hysteresis stage of the Canny pipeline, upstream of the write controller. Consumes post-non-max-suppression gradient magnitudes in raster order. Classifies each pixel as strong, weak or none, and resolves weak pixels against their 8-neighbourhood using two line buffers. Emits one edge bit per pixel (hysteresis_result, write_enable) in raster order, exactly IMG_WIDTH*IMG_HEIGHT per frame.

Parameters:
IMG_WIDTH, 512, pixels per row
IMG_HEIGHT, 512, rows per frame
MAG_W, 8, gradient magnitude width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mag_in  in  MAG_W  gradient magnitude of the current pixel
mag_valid  in  1  mag_in is valid; accepted when mag_valid && in_ready
in_ready  out  1  block can accept a pixel; low during FLUSH and DONE
high_thresh  in  MAG_W  strong threshold, latched at first pixel of each frame
low_thresh  in  MAG_W  weak threshold, latched at first pixel of each frame
hysteresis_result  out  1  1 = edge pixel; qualified by write_enable
write_enable  out  1  one-cycle pulse per output pixel
frame_done  out  1  one-cycle pulse in the cycle after the final write_enable of a frame

Behaviour:
- Interface: single clock, reset synchronous active-high. On rst: state FILL, all counters 0, hysteresis_result=0, write_enable=0, frame_done=0, in_ready=1. Line-buffer contents are not cleared; border masking makes stale data unobservable.
- Classification on accept: STRONG if mag>=high; WEAK if low<=mag<high; otherwise NONE. If low>high, no pixel is WEAK. All comparisons are unsigned.
- Window: the 3x3 class window is centred on the pixel accepted IMG_WIDTH+1 pixels earlier. Neighbours outside the image (x<0, x>=W, y<0, y>=H) are forced NONE. There is no horizontal wrap between the end of one row and the start of the next.
- Decision: edge = centre STRONG, or centre WEAK and at least one of the 8 neighbours STRONG. This is single-pass; there is no transitive propagation.
- Output is registered: write_enable/hysteresis_result assert in the cycle after the triggering accept or flush step.
- FSM:
  - FILL: the first W+1 accepted pixels produce no output. Then go to RUN.
  - RUN: each accepted pixel produces exactly one output. After the W*H-th accept, go to FLUSH.
  - FLUSH: in_ready=0. Injects W+1 NONE pixels, one per cycle, each producing one output. Then go to DONE.
  - DONE: one cycle. frame_done=1, counters cleared, then back to FILL.
- Input gaps (mag_valid=0) stall the window; no output is produced that cycle.
- Counters: x (0..W-1) and y (0..H-1) for the input position; centre coordinates are tracked separately for masking.
- rst asserted mid-frame aborts the frame with no further outputs. The next accepted pixel is (0,0) of a new frame.

Optional Feature:
HYST_EDGE_COUNT_EN
- Defined: adds output edge_count [$clog2(W*H+1)-1:0]. It counts outputs with hysteresis_result=1, holds the total from the frame_done cycle until the next frame's first output, and is cleared by rst.
- Undefined: no port and no counter logic.

Decomposition:
- canny_pkg: IMG_WIDTH/IMG_HEIGHT defaults; pix_class_t enum {CLS_NONE, CLS_WEAK, CLS_STRONG} (2 bits); hyst_state_t enum {FILL, RUN, FLUSH, DONE}.
- Sub-module line_buffer: IMG_WIDTH-deep, 2-bit-wide delay line with a shift enable and read-before-write semantics. Two instances are chained.

Test Plan:
(The bench uses IMG_WIDTH=4, IMG_HEIGHT=4, high=100, low=50.)
- Reset: hold rst 2 cycles -> write_enable=0, frame_done=0, in_ready=1.
- All-zero frame, 16 pixels with mag_valid=1 -> first write_enable 1 cycle after the 6th accept; 16 pulses total, all result=0; frame_done once, 1 cycle after the 16th; in_ready=0 for the 5 flush cycles.
- mag=200 at (1,1), mag=60 at (2,2), mag=60 at (3,3) isolated from strong, rest 0 -> result=1 only at output indices 5 and 10.
- No wrap: mag=200 at (3,0), mag=60 at (0,1) -> index 4 =0, index 3 =1.
- mag_valid toggled every other cycle on the all-zero frame -> still exactly 16 outputs, correct order, no output on idle cycles.
- rst after 7 accepts, then a full frame with mag=200 at (0,0) -> exactly 16 outputs, only index 0 =1; HYST_EDGE_COUNT_EN build: edge_count=1.
